// File: rtl/rtype_seq_pkg.sv
// Shared definitions for the R-type sequencer: FSM state encoding,
// ALU control codes and the R-type opcode/funct7 constants.
package rtype_seq_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DECODE = 3'd1,
        READ   = 3'd2,
        EXEC   = 3'd3,
        WRITE  = 3'd4,
        DONE   = 3'd5,
        ERROR  = 3'd6
    } state_t;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_XOR = 4'b0011;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_SLL = 4'b1000;
    localparam logic [3:0] ALU_SRL = 4'b1001;

    localparam logic [6:0] OPCODE_RTYPE = 7'b0110011;
    localparam logic [6:0] FUNCT7_BASE  = 7'b0000000;
    localparam logic [6:0] FUNCT7_ALT   = 7'b0100000;

endpackage

// File: rtl/rtype_sequencer_decode.sv
// Combinational funct7/funct3 -> alu_ctrl decoder with a legal flag.
// Anything outside the supported R-type set decodes to ADD with legal = 0.
module rtype_decode
    import rtype_seq_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    output logic [3:0] alu_ctrl,
    output logic       legal
);

    always_comb begin
        alu_ctrl = ALU_ADD;
        legal    = 1'b0;
        if (opcode == OPCODE_RTYPE) begin
            if (funct7 == FUNCT7_BASE) begin
                legal = 1'b1;
                case (funct3)
                    3'b000:  alu_ctrl = ALU_ADD;
                    3'b111:  alu_ctrl = ALU_AND;
                    3'b110:  alu_ctrl = ALU_OR;
                    3'b100:  alu_ctrl = ALU_XOR;
                    3'b010:  alu_ctrl = ALU_SLT;
                    3'b001:  alu_ctrl = ALU_SLL;
                    3'b101:  alu_ctrl = ALU_SRL;
                    default: legal    = 1'b0;
                endcase
            end else if (funct7 == FUNCT7_ALT && funct3 == 3'b000) begin
                alu_ctrl = ALU_SUB;
                legal    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rtype_sequencer.sv
// Multi-cycle R-type instruction sequencer driving register-file and ALU controls.
// Define RTYPE_SEQ_ILLEGAL_CHK_EN to reject unsupported encodings via the ERROR state.
//
// Handshake: an instruction is taken on a rising clk edge where instr_valid and
// instr_ready are both 1; instr_ready is 1 only in IDLE, and instr_valid is
// ignored in all other states. instr needs to be stable only on that edge.
module rtype_sequencer
    import rtype_seq_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        instr_valid,
    input  logic [31:0] instr,
    output logic        instr_ready,
    input  logic        zero_flag,
    output logic [4:0]  mem_read_addr_1,
    output logic [4:0]  mem_read_addr_2,
    output logic [4:0]  mem_write_addr,
    output logic [3:0]  alu_ctrl,
    output logic        r_or_w,
    output logic        done,
    output logic        zero_out,
    output logic        illegal,
    output state_t      debug_state
);

    state_t     state;
    state_t     next_state;
    logic [3:0] dec_alu_ctrl;
    logic       dec_legal;
    logic [4:0] rd_q;
    logic       accept;

    rtype_decode u_decode (
        .opcode   (instr[6:0]),
        .funct3   (instr[14:12]),
        .funct7   (instr[31:25]),
        .alu_ctrl (dec_alu_ctrl),
        .legal    (dec_legal)
    );

    assign accept      = (state == IDLE) && instr_valid;
    assign debug_state = state;

`ifdef RTYPE_SEQ_ILLEGAL_CHK_EN
    logic legal_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            legal_q <= 1'b1;
            illegal <= 1'b0;
        end else begin
            if (accept) begin
                legal_q <= dec_legal;
            end
            illegal <= (next_state == ERROR);
        end
    end
`else
    logic legal_unused;

    assign legal_unused = dec_legal;
    assign illegal      = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (instr_valid) next_state = DECODE;
`ifdef RTYPE_SEQ_ILLEGAL_CHK_EN
            DECODE:  next_state = legal_q ? READ : ERROR;
`else
            DECODE:  next_state = READ;
`endif
            READ:    next_state = EXEC;
            EXEC:    next_state = WRITE;
            WRITE:   next_state = DONE;
            DONE:    next_state = IDLE;
            ERROR:   next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Outputs are registered off next_state so they line up with the state they describe.
    always_ff @(posedge clk) begin
        if (reset) begin
            instr_ready     <= 1'b1;
            mem_read_addr_1 <= '0;
            mem_read_addr_2 <= '0;
            mem_write_addr  <= '0;
            alu_ctrl        <= ALU_ADD;
            r_or_w          <= 1'b1;
            done            <= 1'b0;
            zero_out        <= 1'b0;
            rd_q            <= '0;
        end else begin
            instr_ready <= (next_state == IDLE);
            done        <= (next_state == DONE);
            r_or_w      <= !((next_state == WRITE) && (rd_q != 5'd0));
            if (accept) begin
                mem_read_addr_1 <= instr[19:15];
                mem_read_addr_2 <= instr[24:20];
                alu_ctrl        <= dec_alu_ctrl;
                rd_q            <= instr[11:7];
            end
            if (next_state == WRITE) begin
                mem_write_addr <= rd_q;
            end
            if (state == EXEC) begin
                zero_out <= zero_flag;
            end
        end
    end

endmodule
